// File: rtl/out_bank_sched.sv
// -----------------------------------------------------------------------------
// out_bank_sched
//   Scheduler for the rotating codeword banks shared by the input writer, the
//   decoder and the output stage of the RS(204,188) decoder. Each bank moves
//   through FREE -> FILL -> DEC -> RDY -> READ -> FREE. Banks are taken in
//   strict round-robin order through three mod-NBANK pointers: write, decode
//   and read.
//
// Ports
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   in_start  in   pulse: first byte of a new input codeword
//   in_end    in   pulse: last byte of the codeword has been written
//   dec_done  in   pulse: decoder finished the oldest decoding bank
//   out_done  in   pulse: out_stage emitted its last byte
//   wr_bank   out  bank the input writer must write
//   wr_en     out  high while the current input codeword owns wr_bank
//   dec_bank  out  bank currently presented to the decoder
//   rd_bank   out  bank out_stage must read
//   out_go    out  one-cycle start pulse to out_stage
//   rd_busy   out  high from out_go until out_done
//   overflow  out  pulse: in_start found no free bank, codeword dropped
//   seq_err   out  pulse: in_end/dec_done/out_done with no matching bank
// -----------------------------------------------------------------------------
module out_bank_sched #(
    parameter int NBANK = 3,
    parameter int BW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_start,
    input  logic          in_end,
    input  logic          dec_done,
    input  logic          out_done,
    output logic [BW-1:0] wr_bank,
    output logic          wr_en,
    output logic [BW-1:0] dec_bank,
    output logic [BW-1:0] rd_bank,
    output logic          out_go,
    output logic          rd_busy,
    output logic          overflow,
    output logic          seq_err
);

    typedef enum logic [2:0] {
        B_FREE = 3'd0,
        B_FILL = 3'd1,
        B_DEC  = 3'd2,
        B_RDY  = 3'd3,
        B_READ = 3'd4
    } bank_state_t;

    bank_state_t   bank_q [NBANK];
    bank_state_t   bank_d [NBANK];

    logic [BW-1:0] wr_ptr, wr_ptr_d;
    logic [BW-1:0] dec_ptr, dec_ptr_d;
    logic [BW-1:0] rd_ptr, rd_ptr_d;

    logic [BW-1:0] wr_bank_d, rd_bank_d;
    logic          wr_en_d, rd_busy_d;
    logic          out_go_d, overflow_d, seq_err_d;

    function automatic logic [BW-1:0] ptr_inc(input logic [BW-1:0] p);
        if (p == BW'(NBANK - 1))
            return '0;
        else
            return p + 1'b1;
    endfunction

    assign dec_bank = dec_ptr;

    always_comb begin
        bank_d     = bank_q;
        wr_ptr_d   = wr_ptr;
        dec_ptr_d  = dec_ptr;
        rd_ptr_d   = rd_ptr;
        wr_bank_d  = wr_bank;
        wr_en_d    = wr_en;
        rd_bank_d  = rd_bank;
        rd_busy_d  = rd_busy;
        out_go_d   = 1'b0;
        overflow_d = 1'b0;
        seq_err_d  = 1'b0;

        // Read launch looks only at registered state. It can never collide
        // with out_done (which needs rd_busy=1) and touches a RDY bank that no
        // other event below can touch.
        if (!rd_busy && bank_q[rd_ptr] == B_RDY) begin
            bank_d[rd_ptr] = B_READ;
            rd_bank_d      = rd_ptr;
            rd_ptr_d       = ptr_inc(rd_ptr);
            out_go_d       = 1'b1;
            rd_busy_d      = 1'b1;
        end

        // Events are applied in priority order on the working copy so that,
        // for example, a bank freed by out_done is allocatable this cycle.
        if (out_done) begin
            if (rd_busy) begin
                bank_d[rd_bank] = B_FREE;
                rd_busy_d       = 1'b0;
                // Pre-point rd_bank at the next bank so it is settled a cycle
                // before the following out_go.
                rd_bank_d       = rd_ptr;
            end else begin
                seq_err_d = 1'b1;
            end
        end

        if (dec_done) begin
            if (bank_d[dec_ptr] == B_DEC) begin
                bank_d[dec_ptr] = B_RDY;
                dec_ptr_d       = ptr_inc(dec_ptr);
            end else begin
                seq_err_d = 1'b1;
            end
        end

        if (in_end) begin
            if (wr_en) begin
                bank_d[wr_bank] = B_DEC;
                wr_en_d         = 1'b0;
            end else begin
                seq_err_d = 1'b1;
            end
        end

        if (in_start) begin
            // A still-open codeword (missing in_end) is closed as if in_end came.
            if (wr_en_d) begin
                bank_d[wr_bank] = B_DEC;
                wr_en_d         = 1'b0;
                seq_err_d       = 1'b1;
            end
            if (bank_d[wr_ptr] == B_FREE) begin
                bank_d[wr_ptr] = B_FILL;
                wr_bank_d      = wr_ptr;
                wr_en_d        = 1'b1;
                wr_ptr_d       = ptr_inc(wr_ptr);
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NBANK; i++) bank_q[i] <= B_FREE;
            wr_ptr   <= '0;
            dec_ptr  <= '0;
            rd_ptr   <= '0;
            wr_bank  <= '0;
            wr_en    <= 1'b0;
            rd_bank  <= '0;
            rd_busy  <= 1'b0;
            out_go   <= 1'b0;
            overflow <= 1'b0;
            seq_err  <= 1'b0;
        end else begin
            bank_q   <= bank_d;
            wr_ptr   <= wr_ptr_d;
            dec_ptr  <= dec_ptr_d;
            rd_ptr   <= rd_ptr_d;
            wr_bank  <= wr_bank_d;
            wr_en    <= wr_en_d;
            rd_bank  <= rd_bank_d;
            rd_busy  <= rd_busy_d;
            out_go   <= out_go_d;
            overflow <= overflow_d;
            seq_err  <= seq_err_d;
        end
    end

endmodule

// File: tb/tb_out_bank_sched.sv
// -----------------------------------------------------------------------------
// tb_out_bank_sched
//   Self-checking bench for out_bank_sched. A reference model tracks codeword
//   counts (allocated, closed, decoded, launched, freed); since banks rotate
//   strictly, every bank index and free/busy condition follows from those
//   counts modulo NBANK. Directed scenarios are followed by random traffic.
// -----------------------------------------------------------------------------
module tb_out_bank_sched;

    localparam int NBANK = 3;
    localparam int BW    = 2;

    logic          clk = 1'b0;
    logic          reset, in_start, in_end, dec_done, out_done;
    logic [BW-1:0] wr_bank, dec_bank, rd_bank;
    logic          wr_en, out_go, rd_busy, overflow, seq_err;

    always #5 clk = ~clk;

    out_bank_sched #(.NBANK(NBANK), .BW(BW)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_start (in_start),
        .in_end   (in_end),
        .dec_done (dec_done),
        .out_done (out_done),
        .wr_bank  (wr_bank),
        .wr_en    (wr_en),
        .dec_bank (dec_bank),
        .rd_bank  (rd_bank),
        .out_go   (out_go),
        .rd_busy  (rd_busy),
        .overflow (overflow),
        .seq_err  (seq_err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: counts of codewords at each life stage.
    int n_alloc, n_closed, n_dec, n_launch, n_freed;
    bit m_busy, m_go, m_ovf, m_serr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input bit e, input bit d, input bit o);
        bit launch;
        if (r) begin
            n_alloc = 0; n_closed = 0; n_dec = 0; n_launch = 0; n_freed = 0;
            m_busy = 0; m_go = 0; m_ovf = 0; m_serr = 0;
            return;
        end
        launch = !m_busy && (n_launch < n_dec);
        m_go = 0; m_ovf = 0; m_serr = 0;
        if (o) begin
            if (m_busy) begin n_freed++; m_busy = 0; end
            else m_serr = 1;
        end
        if (d) begin
            if (n_dec < n_closed) n_dec++;
            else m_serr = 1;
        end
        if (e) begin
            if (n_alloc > n_closed) n_closed++;
            else m_serr = 1;
        end
        if (s) begin
            if (n_alloc > n_closed) begin n_closed++; m_serr = 1; end
            if (n_alloc - n_freed < NBANK) n_alloc++;
            else m_ovf = 1;
        end
        if (launch) begin n_launch++; m_busy = 1; m_go = 1; end
    endtask

    task automatic check_all();
        int exp_wb, exp_rb;
        exp_wb = (n_alloc == 0) ? 0 : (n_alloc - 1) % NBANK;
        exp_rb = m_busy ? (n_launch - 1) % NBANK : n_launch % NBANK;
        chk("wr_bank",  32'(wr_bank),  32'(exp_wb));
        chk("wr_en",    32'(wr_en),    32'(n_alloc > n_closed));
        chk("dec_bank", 32'(dec_bank), 32'(n_dec % NBANK));
        chk("rd_bank",  32'(rd_bank),  32'(exp_rb));
        chk("out_go",   32'(out_go),   32'(m_go));
        chk("rd_busy",  32'(rd_busy),  32'(m_busy));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("seq_err",  32'(seq_err),  32'(m_serr));
    endtask

    // One clock: drive on the falling edge, model on the rising edge, compare 1 ns later.
    task automatic cyc(input bit r, input bit s, input bit e, input bit d, input bit o);
        @(negedge clk);
        reset = r; in_start = s; in_end = e; dec_done = d; out_done = o;
        @(posedge clk);
        model_step(r, s, e, d, o);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; in_start = 0; in_end = 0; dec_done = 0; out_done = 0;

        // Reset state
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_rd_busy", 32'(rd_busy), 0);

        // 1: single codeword end to end
        cyc(0, 1, 0, 0, 0);
        chk("t1_wr_bank", 32'(wr_bank), 0);
        chk("t1_wr_en", 32'(wr_en), 1);
        idle(202);
        cyc(0, 0, 1, 0, 0);
        chk("t1_wr_en_low", 32'(wr_en), 0);
        idle(196);
        cyc(0, 0, 0, 1, 0);
        chk("t1_go_early", 32'(out_go), 0);
        cyc(0, 0, 0, 0, 0);
        chk("t1_out_go", 32'(out_go), 1);
        chk("t1_rd_bank", 32'(rd_bank), 0);
        chk("t1_rd_busy", 32'(rd_busy), 1);
        idle(20);
        chk("t1_busy_hold", 32'(rd_busy), 1);
        cyc(0, 0, 0, 0, 1);
        chk("t1_busy_drop", 32'(rd_busy), 0);

        // 2: three codewords, then a 4th with no free bank
        cyc(1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 0, 0, 0);
            chk("t2_wr_bank", 32'(wr_bank), 32'(k));
            idle(3);
            cyc(0, 0, 1, 0, 0);
        end
        cyc(0, 0, 0, 1, 0);              // bank 0 decoded -> launched
        idle(2);
        cyc(0, 1, 0, 0, 0);
        chk("t2_overflow", 32'(overflow), 1);
        chk("t2_wr_en", 32'(wr_en), 0);
        cyc(0, 0, 0, 0, 0);
        chk("t2_ovf_pulse", 32'(overflow), 0);

        // 4: two dec_done while reading bank 0
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        chk("t4_no_go", 32'(out_go), 0);

        // 3: out_done and in_start together with all banks busy
        cyc(0, 1, 0, 0, 1);
        chk("t3_overflow", 32'(overflow), 0);
        chk("t3_wr_bank", 32'(wr_bank), 0);
        chk("t3_wr_en", 32'(wr_en), 1);
        chk("t4_go_gap", 32'(out_go), 0);
        cyc(0, 0, 0, 0, 0);
        chk("t4_out_go", 32'(out_go), 1);
        chk("t4_rd_bank", 32'(rd_bank), 1);
        idle(3);
        cyc(0, 0, 0, 0, 1);
        idle(1);
        chk("t4_rd_bank2", 32'(rd_bank), 2);

        // 5: stray events in idle state
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        chk("t5_dec_serr", 32'(seq_err), 1);
        cyc(0, 0, 0, 0, 0);
        chk("t5_serr_pulse", 32'(seq_err), 0);
        cyc(0, 0, 1, 0, 0);
        chk("t5_end_serr", 32'(seq_err), 1);
        cyc(0, 0, 0, 0, 1);
        chk("t5_out_serr", 32'(seq_err), 1);
        chk("t5_dec_bank", 32'(dec_bank), 0);
        idle(1);

        // 6: reset with bank 1 READ and bank 2 FILL
        cyc(0, 1, 0, 0, 0); cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 1, 0);
        idle(3);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0); cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        chk("t6_pre_busy", 32'(rd_busy), 1);
        chk("t6_pre_wr_bank", 32'(wr_bank), 2);
        cyc(1, 0, 0, 0, 0);
        chk("t6_rst_rd_busy", 32'(rd_busy), 0);
        chk("t6_rst_rd_bank", 32'(rd_bank), 0);
        chk("t6_rst_wr_en", 32'(wr_en), 0);
        cyc(0, 1, 0, 0, 0);
        chk("t6_wr_bank", 32'(wr_bank), 0);

        // Random traffic, including missing in_end and stray pulses
        for (int i = 0; i < 4000; i++) begin
            bit r, s, e, d, o;
            r = ($urandom_range(0, 399) == 0);
            s = ($urandom_range(0, 99) < 10);
            e = ($urandom_range(0, 99) < 12);
            d = ($urandom_range(0, 99) < 12);
            o = m_busy ? ($urandom_range(0, 99) < 15) : ($urandom_range(0, 99) < 2);
            cyc(r, s, e, d, o);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
